wave_dds: RTL and testbench
===========================

# wave_dds

Parametrised direct-digital-synthesis waveform generator: a phase accumulator with burst-cycle counting and four selectable waveshapes (sawtooth, falling ramp, triangle, variable-duty square). It replaces the fixed-width sawtooth generator as the per-channel sample source feeding the DAC path, and takes a pre-computed phase increment instead of a frequency in Hz. It has an explicit IDLE/RUN/DONE control sequence and a one-cycle completion pulse.

## Interface
- PHASE_W, 32, phase accumulator width; one output period = 2^PHASE_W phase units; must be >= OUT_W+1
- OUT_W, 12, sample width
- CYC_W, 16, burst cycle counter width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- run  in  1  level; 1 = start/continue, 0 = stop/abort
- mode  in  2  0 saw, 1 falling ramp, 2 triangle, 3 square; latched at start
- delta  in  PHASE_W  phase increment per clock; latched at start
- cycles  in  CYC_W  burst length in periods, 0 = continuous; latched at start
- duty  in  OUT_W  square threshold; latched at start
- wave  out  OUT_W  registered sample
- active  out  1  1 while in RUN
- done  out  1  one-cycle pulse on burst completion

## Operation
- States: IDLE, RUN, DONE.
- IDLE: phase held at 0. On a rising edge with run=1: latch mode/delta/cycles/duty into *_q, clear cyc_cnt, phase<=0, go RUN.
- RUN: each edge phase<=phase+delta_q (modulo 2^PHASE_W). Carry-out marks a completed period.
  - If cycles_q!=0 and the carry occurs when cyc_cnt==cycles_q-1: phase<=0, go DONE, done<=1 for that one cycle.
  - Otherwise carry increments cyc_cnt. In continuous mode cyc_cnt wraps silently.
  - run=0 sampled in RUN: abort, phase<=0, go IDLE, no done pulse. This takes priority over completion on the same edge.
- DONE: phase held at 0. Stays until run=0 sampled, then goes IDLE. Burst does not restart while run stays high.
- Input changes during RUN/DONE are ignored until the next start.
- Shaping, with p = phase[PHASE_W-1 -: OUT_W] and t = phase[PHASE_W-2 -: OUT_W]:
  - saw: p
  - ramp: ~p
  - triangle: phase MSB ? ~t : t
  - square: (p < duty_q) ? all-ones : 0. duty_q=0 gives constant 0.
- wave <= shape(phase, mode_q) every edge in all states. In IDLE/DONE it shows the phase-0 value (saw 0, ramp all-ones, triangle 0, square all-ones if duty_q>0).
- delta_q=0: phase frozen, burst never completes; only run=0 exits.

## Timing
- Reset (async assert): state IDLE, phase 0, cyc_cnt 0, all *_q 0, wave 0, active 0, done 0. Deassertion is synchronous to clk at the integrating level.
- Start: run sampled 1 at edge E0 gives active=1 after E0; first increment at E1; wave reflects the phase of the previous cycle (1-cycle lag behind phase).
- Completion: the wrapping edge sets done=1 and active=0 simultaneously; done clears at the next edge.
- Burst of N periods with delta=2^PHASE_W/K lasts exactly N*K RUN cycles.
- Abort: active drops on the edge after run is sampled 0.

## Structure
- Package wave_gen_pkg: mode_t enum (MODE_SAW, MODE_RAMP, MODE_TRI, MODE_SQUARE) and state_t enum (IDLE, RUN, DONE).
- Sub-module wave_shaper: combinational phase/mode/duty to sample, parametrised on PHASE_W and OUT_W, so it can be reused by multi-channel variants. The FSM, accumulator and counter stay in wave_dds.

## Test plan
- Saw, PHASE_W=32, OUT_W=12, delta=2^28, cycles=0: wave steps 0,256,…,3840,0 every cycle; active stays 1; done never fires.
- Burst: delta=2^28, cycles=3: done pulses once exactly 48 cycles after first increment; active falls with it; wave returns to 0; no restart while run=1; run 0→1 starts a new burst.
- Triangle, delta=2^27: 32-cycle period, wave rises 0→3840 in steps of 256 for 16 cycles, then 4095 down in steps of 256; ramp mode gives 4095-saw.
- Square, duty=1024, delta=2^28: wave 4095 for 4 cycles then 0 for 12 per period; duty=0 gives constant 0.
- Abort: run drops mid-burst in cycle 20 of a cycles=3 burst: IDLE next edge, no done pulse, wave 0; simultaneous run=0 with final wrap also produces no done.
- Async reset asserted mid-RUN without a clock edge: all outputs 0 immediately; after release with run=1, a fresh burst starts from phase 0.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// Shared types for the DDS waveform generator family: waveshape selection
// and the burst control sequence states.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SAW    = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SQUARE = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wave_shaper.sv
// Combinational phase-to-sample shaper: maps an accumulator phase onto one of
// four waveshapes. Stateless so multi-channel variants can share it.
module wave_shaper
    import wave_gen_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 12
) (
    input  logic [PHASE_W-1:0] phase_i,
    input  mode_t              mode_i,
    input  logic [OUT_W-1:0]   duty_i,
    output logic [OUT_W-1:0]   wave_o
);

    logic [OUT_W-1:0] p;
    logic [OUT_W-1:0] t;

    assign p = phase_i[PHASE_W-1 -: OUT_W];
    // t skips the MSB so the triangle covers full scale on each half period.
    assign t = phase_i[PHASE_W-2 -: OUT_W];

    generate
        if (PHASE_W > OUT_W + 1) begin : g_low_bits
            logic unused_low_phase;
            assign unused_low_phase = ^phase_i[PHASE_W-OUT_W-2:0];
        end
    endgenerate

    // NOTE: every output of a combinational block gets a default first; a
    // path that leaves it unassigned would infer a latch.
    always_comb begin
        wave_o = '0;
        case (mode_i)
            MODE_SAW:    wave_o = p;
            MODE_RAMP:   wave_o = ~p;
            MODE_TRI:    wave_o = phase_i[PHASE_W-1] ? ~t : t;
            MODE_SQUARE: wave_o = (p < duty_i) ? '1 : '0;
            default:     wave_o = '0;
        endcase
    end

endmodule

// File: rtl/wave_dds.sv
// DDS waveform generator: phase accumulator with burst-period counting,
// IDLE/RUN/DONE control and a registered, shaped sample output.
module wave_dds
    import wave_gen_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 12,
    parameter int CYC_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] delta,
    input  logic [CYC_W-1:0]   cycles,
    input  logic [OUT_W-1:0]   duty,
    output logic [OUT_W-1:0]   wave,
    output logic               active,
    output logic               done
);

    state_t             state_q,  state_d;
    logic [PHASE_W-1:0] phase_q,  phase_d;
    logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
    mode_t              mode_q,   mode_d;
    logic [PHASE_W-1:0] delta_q,  delta_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;
    logic [OUT_W-1:0]   duty_q,   duty_d;
    logic               done_q,   done_d;
    logic [OUT_W-1:0]   wave_q;

    logic [PHASE_W-1:0] phase_sum;
    logic               carry;
    logic               last_period;
    logic [OUT_W-1:0]   shape_w;

    // Carry out of the accumulator marks the end of one output period.
    assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, delta_q};
    assign last_period = (cycles_q != '0) && (cyc_cnt_q == cycles_q - CYC_W'(1));

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cyc_cnt_d = cyc_cnt_q;
        mode_d    = mode_q;
        delta_d   = delta_q;
        cycles_d  = cycles_q;
        duty_d    = duty_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (run) begin
                    mode_d    = mode_t'(mode);
                    delta_d   = delta;
                    cycles_d  = cycles;
                    duty_d    = duty;
                    cyc_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Abort wins over a completion landing on the same edge.
                if (!run) begin
                    phase_d = '0;
                    state_d = IDLE;
                end else if (carry && last_period) begin
                    phase_d = '0;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase_sum;
                    if (carry) begin
                        cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
                    end
                end
            end
            DONE: begin
                phase_d = '0;
                if (!run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                phase_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    wave_shaper #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W)
    ) u_shaper (
        .phase_i (phase_q),
        .mode_i  (mode_q),
        .duty_i  (duty_q),
        .wave_o  (shape_w)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // The design has no memories; every register gets an explicit reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            cyc_cnt_q <= '0;
            mode_q    <= MODE_SAW;
            delta_q   <= '0;
            cycles_q  <= '0;
            duty_q    <= '0;
            done_q    <= 1'b0;
            wave_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cyc_cnt_q <= cyc_cnt_d;
            mode_q    <= mode_d;
            delta_q   <= delta_d;
            cycles_q  <= cycles_d;
            duty_q    <= duty_d;
            done_q    <= done_d;
            wave_q    <= shape_w;
        end
    end

    assign wave   = wave_q;
    assign active = (state_q == RUN);
    assign done   = done_q;

endmodule

// File: tb/tb_wave_dds.sv
// Self-checking bench for wave_dds: a step-count phase model (phase = n*delta,
// periods = n*delta / 2^32) predicts wave/active/done every cycle.
module tb_wave_dds;

    localparam int PHASE_W = 32;
    localparam int OUT_W   = 12;
    localparam int CYC_W   = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               run;
    logic [1:0]         mode;
    logic [PHASE_W-1:0] delta;
    logic [CYC_W-1:0]   cycles;
    logic [OUT_W-1:0]   duty;
    logic [OUT_W-1:0]   wave;
    logic               active;
    logic               done;

    int checks = 0;
    int errors = 0;

    wave_dds #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W),
        .CYC_W   (CYC_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .mode    (mode),
        .delta   (delta),
        .cycles  (cycles),
        .duty    (duty),
        .wave    (wave),
        .active  (active),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference model: bursting flag, finished flag, step count since start.
    bit              m_running, m_finished;
    longint unsigned m_n, m_phase, m_delta;
    int              m_mode, m_cycles, m_duty;
    logic [OUT_W-1:0] exp_wave;
    logic            exp_active, exp_done;

    function automatic logic [OUT_W-1:0] ref_shape(longint unsigned ph, int md, int dty);
        int saw, pos, v;
        saw = int'(ph >> 20);
        pos = int'(ph >> 19);
        case (md)
            0:       v = saw;
            1:       v = 4095 - saw;
            2:       v = (pos < 4096) ? pos : 8191 - pos;
            default: v = (saw < dty) ? 4095 : 0;
        endcase
        return 12'(v);
    endfunction

    task automatic model_reset();
        m_running = 0; m_finished = 0; m_n = 0; m_phase = 0; m_delta = 0;
        m_mode = 0; m_cycles = 0; m_duty = 0;
        exp_wave = '0; exp_active = 0; exp_done = 0;
    endtask

    task automatic model_edge(input logic r);
        longint unsigned total;
        exp_wave = ref_shape(m_phase, m_mode, m_duty);
        exp_done = 0;
        if (m_running) begin
            if (!r) begin
                m_running = 0;
                m_phase   = 0;
            end else begin
                m_n++;
                total = m_n * m_delta;
                if (m_cycles != 0 && (total >> 32) >= longint'(m_cycles)) begin
                    m_running  = 0;
                    m_finished = 1;
                    m_phase    = 0;
                    exp_done   = 1;
                end else begin
                    m_phase = total & 64'hFFFF_FFFF;
                end
            end
        end else if (m_finished) begin
            if (!r) m_finished = 0;
        end else if (r) begin
            m_mode = int'(mode); m_delta = longint'(delta);
            m_cycles = int'(cycles); m_duty = int'(duty);
            m_n = 0; m_phase = 0; m_running = 1;
        end
        exp_active = m_running;
    endtask

    // Drive run at a falling edge, let one rising edge pass, land on the next falling edge.
    task automatic tick(input logic r);
        run = r;
        model_edge(r);
        @(negedge clk);
    endtask

    task automatic setup(input int md, input longint unsigned dl, input int cy, input int dt);
        mode = 2'(md); delta = 32'(dl); cycles = 16'(cy); duty = 12'(dt);
    endtask

    task automatic test_reset();
        reset_n = 0; run = 0;
        setup(0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({wave, active, done} !== 14'd0) begin
            errors++;
            $display("FAIL reset_hold: got wave=%0d active=%0b done=%0b, expected all 0", wave, active, done);
        end
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick(0);
            checks++;
            if ({wave, active, done} !== {exp_wave, exp_active, exp_done}) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got wave=%0d active=%0b done=%0b, expected wave=%0d active=%0b done=%0b",
                         i, wave, active, done, exp_wave, exp_active, exp_done);
            end
        end
    endtask

    task automatic test_saw_continuous();
        int dones = 0;
        setup(0, 64'h1000_0000, 0, 0);
        tick(1);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (done) dones++;
            checks++;
            if ({wave, active, done} !== {exp_wave, exp_active, exp_done}) begin
                errors++;
                $display("FAIL saw[%0d]: got wave=%0d active=%0b done=%0b, expected wave=%0d active=%0b done=%0b",
                         i, wave, active, done, exp_wave, exp_active, exp_done);
            end
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL saw_no_done: got %0d done pulses, expected 0", dones);
        end
        tick(0);
        tick(0);
    endtask

    task automatic test_burst();
        int done_at = -1, dones = 0;
        setup(0, 64'h1000_0000, 3, 0);
        tick(1);
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (done) begin dones++; if (done_at < 0) done_at = i; end
            checks++;
            if ({wave, active, done} !== {exp_wave, exp_active, exp_done}) begin
                errors++;
                $display("FAIL burst[%0d]: got wave=%0d active=%0b done=%0b, expected wave=%0d active=%0b done=%0b",
                         i, wave, active, done, exp_wave, exp_active, exp_done);
            end
        end
        checks++;
        if (done_at !== 48 || dones !== 1) begin
            errors++;
            $display("FAIL burst_len: got done at increment %0d (%0d pulses), expected 48 (1 pulse)", done_at, dones);
        end
        checks++;
        if (wave !== 12'd0 || active !== 1'b0) begin
            errors++;
            $display("FAIL burst_hold: got wave=%0d active=%0b, expected wave=0 active=0", wave, active);
        end
        tick(0);
        tick(1);
        checks++;
        if (active !== 1'b1 || active !== exp_active) begin
            errors++;
            $display("FAIL burst_restart: got active=%0b, expected 1", active);
        end
        tick(0);
        tick(0);
    endtask

    task automatic test_tri_ramp();
        setup(2, 64'h0800_0000, 0, 0);
        tick(1);
        for (int i = 0; i < 70; i++) begin
            tick(1);
            checks++;
            if ({wave, active, done} !== {exp_wave, exp_active, exp_done}) begin
                errors++;
                $display("FAIL tri[%0d]: got wave=%0d active=%0b done=%0b, expected wave=%0d active=%0b done=%0b",
                         i, wave, active, done, exp_wave, exp_active, exp_done);
            end
        end
        tick(0);
        setup(1, 64'h1000_0000, 0, 0);
        tick(1);
        for (int i = 0; i < 36; i++) begin
            tick(1);
            checks++;
            if ({wave, active, done} !== {exp_wave, exp_active, exp_done}) begin
                errors++;
                $display("FAIL ramp[%0d]: got wave=%0d active=%0b done=%0b, expected wave=%0d active=%0b done=%0b",
                         i, wave, active, done, exp_wave, exp_active, exp_done);
            end
        end
        tick(0);
        tick(0);
    endtask

    task automatic test_square();
        int highs = 0;
        for (int pass = 0; pass < 2; pass++) begin
            setup(3, 64'h1000_0000, 0, (pass == 0) ? 1024 : 0);
            tick(1);
            for (int i = 0; i < 40; i++) begin
                tick(1);
                if (pass == 1 && i >= 2 && wave !== 12'd0) highs++;
                checks++;
                if ({wave, active, done} !== {exp_wave, exp_active, exp_done}) begin
                    errors++;
                    $display("FAIL square%0d[%0d]: got wave=%0d active=%0b done=%0b, expected wave=%0d active=%0b done=%0b",
                             pass, i, wave, active, done, exp_wave, exp_active, exp_done);
                end
            end
            tick(0);
        end
        checks++;
        if (highs !== 0) begin
            errors++;
            $display("FAIL square_duty0: got %0d nonzero samples, expected 0", highs);
        end
        tick(0);
    endtask

    task automatic test_abort();
        // Abort in cycle 20, then abort on the very edge that would complete.
        for (int pass = 0; pass < 2; pass++) begin
            int stop_at, dones = 0;
            stop_at = (pass == 0) ? 20 : 48;
            setup(0, 64'h1000_0000, 3, 0);
            tick(1);
            for (int i = 1; i <= stop_at + 3; i++) begin
                tick(i < stop_at);
                if (done) dones++;
                checks++;
                if ({wave, active, done} !== {exp_wave, exp_active, exp_done}) begin
                    errors++;
                    $display("FAIL abort%0d[%0d]: got wave=%0d active=%0b done=%0b, expected wave=%0d active=%0b done=%0b",
                             pass, i, wave, active, done, exp_wave, exp_active, exp_done);
                end
            end
            checks++;
            if (dones !== 0 || wave !== 12'd0 || active !== 1'b0) begin
                errors++;
                $display("FAIL abort%0d_end: got dones=%0d wave=%0d active=%0b, expected dones=0 wave=0 active=0",
                         pass, dones, wave, active);
            end
        end
    endtask

    task automatic test_zero_delta();
        setup(2, 0, 1, 0);
        tick(1);
        for (int i = 0; i < 30; i++) begin
            tick(1);
            checks++;
            if ({wave, active, done} !== {exp_wave, exp_active, exp_done}) begin
                errors++;
                $display("FAIL zero_delta[%0d]: got wave=%0d active=%0b done=%0b, expected wave=%0d active=%0b done=%0b",
                         i, wave, active, done, exp_wave, exp_active, exp_done);
            end
        end
        tick(0);
        tick(0);
    endtask

    task automatic test_async_reset();
        setup(2, 64'h0800_0000, 3, 0);
        tick(1);
        repeat (10) tick(1);
        #2;
        reset_n = 0;
        model_reset();
        #1;
        checks++;
        if ({wave, active, done} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset: got wave=%0d active=%0b done=%0b, expected all 0", wave, active, done);
        end
        @(negedge clk);
        reset_n = 1;
        setup(0, 64'h1000_0000, 1, 0);
        tick(1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checks++;
            if ({wave, active, done} !== {exp_wave, exp_active, exp_done}) begin
                errors++;
                $display("FAIL post_reset[%0d]: got wave=%0d active=%0b done=%0b, expected wave=%0d active=%0b done=%0b",
                         i, wave, active, done, exp_wave, exp_active, exp_done);
            end
        end
        tick(0);
        tick(0);
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            setup(int'($urandom_range(0, 3)), longint'($urandom_range(32'h0200_0000, 32'h4000_0000)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
            tick(1);
            for (int i = 0; i < 300; i++) begin
                tick($urandom_range(0, 149) != 0);
                checks++;
                if ({wave, active, done} !== {exp_wave, exp_active, exp_done}) begin
                    errors++;
                    $display("FAIL random%0d[%0d]: got wave=%0d active=%0b done=%0b, expected wave=%0d active=%0b done=%0b",
                             b, i, wave, active, done, exp_wave, exp_active, exp_done);
                end
            end
            tick(0);
            tick(0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_saw_continuous();
        test_burst();
        test_tri_ramp();
        test_square();
        test_abort();
        test_zero_delta();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
